// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding scoreboard.
// Build option: FWD_LOAD_INTERLOCK_EN enables load-use stall generation.
package fwd_pkg;

  // The stored rd field is sized for the widest supported register file.
  // Narrower address widths are zero-extended on entry.
  localparam int FWD_RD_W_MAX = 16;

  // Select value that means "take the operand from the register file".
  localparam int FWD_SEL_RF = 0;

  // One in-flight producer record.
  typedef struct packed {
    logic                    valid;
    logic                    wren;
    logic [FWD_RD_W_MAX-1:0] rd;
    logic                    load;
  } fwd_entry_t;

  // Select width: it must encode 0 (register file) plus stages 1..depth.
  function automatic int fwd_sel_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Matches one source address against every tracked producer stage. It emits
// the select of the youngest matching stage and flags a hit on a stage-1 load.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = 3,
  parameter int FWD_DEPTH  = 2,
  parameter int SEL_W      = fwd_sel_w(FWD_DEPTH)
) (
  input  logic [REG_ADDR_W-1:0]        src,
  input  fwd_entry_t [FWD_DEPTH-1:0]   ent,
  output logic [SEL_W-1:0]             sel,
  output logic                         ld_hit
);

  logic [FWD_RD_W_MAX-1:0] src_ext;
  logic [FWD_DEPTH-1:0]    hit;
  logic [FWD_DEPTH-1:0]    ld_vec;
  logic                    unused_ld;

  assign src_ext = FWD_RD_W_MAX'(src);

  // Per-stage address match against live, register-writing producers.
  always_comb begin
    hit    = '0;
    ld_vec = '0;
    for (int k = 0; k < FWD_DEPTH; k++) begin
      hit[k]    = ent[k].valid & ent[k].wren & (ent[k].rd == src_ext);
      ld_vec[k] = ent[k].load;
    end
  end

  // Priority encode. The scan runs from oldest to youngest, so the youngest
  // matching stage is written last and wins. Matches are never ORed.
  always_comb begin
    sel = SEL_W'(FWD_SEL_RF);
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (hit[k]) sel = SEL_W'(k + 1);
    end
  end

  // Only a stage-1 load can cause a load-use hazard. Older loads have already
  // produced their data.
  assign ld_hit = hit[0] & ent[0].load;

  // The load flags of older stages are carried along but never examined here.
  assign unused_ld = ^ld_vec;

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use interlock unit. It keeps a FWD_DEPTH-deep shift
// register of in-flight producers and resolves one bypass select per source.
// Build option: FWD_LOAD_INTERLOCK_EN stores load flags and drives ld_stall.
// Without it, ld_stall is 0 and loads forward like ALU results.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter  int REG_ADDR_W = 3,
  parameter  int NUM_SRC    = 2,
  parameter  int FWD_DEPTH  = 2,
  localparam int SEL_W      = fwd_sel_w(FWD_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          adv,
  input  logic                          flush,
  input  logic                          cons_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] cons_src,
  input  logic                          cons_wren,
  input  logic [REG_ADDR_W-1:0]         cons_rd,
  input  logic                          cons_load,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic                          ld_stall
);

  // ent[0] is stage 1, the producer nearest the consumer.
  fwd_entry_t [FWD_DEPTH-1:0] ent;
  fwd_entry_t                 push;
  logic [NUM_SRC-1:0]         ld_hit;
  logic                       load_in;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_match #(
      .REG_ADDR_W (REG_ADDR_W),
      .FWD_DEPTH  (FWD_DEPTH),
      .SEL_W      (SEL_W)
    ) u_match (
      .src    (cons_src[i*REG_ADDR_W +: REG_ADDR_W]),
      .ent    (ent),
      .sel    (fwd_sel[i*SEL_W +: SEL_W]),
      .ld_hit (ld_hit[i])
    );
  end

`ifdef FWD_LOAD_INTERLOCK_EN
  assign ld_stall = cons_valid & (|ld_hit);
  assign load_in  = cons_load;
`else
  logic unused_ld;
  assign ld_stall  = 1'b0;
  assign load_in   = 1'b0;
  assign unused_ld = ^{ld_hit, cons_load};
`endif

  // Entry entering stage 1. A stalled or absent consumer becomes a bubble.
  always_comb begin
    push = '0;
    if (cons_valid && !ld_stall) begin
      push.valid = 1'b1;
      push.wren  = cons_wren;
      push.rd    = FWD_RD_W_MAX'(cons_rd);
      push.load  = load_in;
    end
  end

  // Producer shift register: reset beats flush, and flush beats advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent <= '0;
    end else if (flush) begin
      ent <= '0;
    end else if (adv) begin
      for (int k = FWD_DEPTH - 1; k >= 1; k--) ent[k] <= ent[k-1];
      ent[0] <= push;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard. It uses directed scenarios and then
// a randomized run. Expected values come from a record-list model of
// in-flight producers, indexed by age.
module tb_fwd_scoreboard;

  localparam int AW = 3;
  localparam int NS = 2;
  localparam int D  = 2;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst, adv, flush, cons_valid, cons_wren, cons_load;
  logic [NS*AW-1:0] cons_src;
  logic [AW-1:0] cons_rd;
  logic [NS*SW-1:0] fwd_sel;
  logic          ld_stall;

  int errors = 0;
  int checks = 0;

  // Model: age 1 is the youngest producer.
  bit m_v [1:D];
  bit m_w [1:D];
  int m_rd[1:D];
  bit m_ld[1:D];

  fwd_scoreboard #(.REG_ADDR_W(AW), .NUM_SRC(NS), .FWD_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .adv(adv), .flush(flush),
    .cons_valid(cons_valid), .cons_src(cons_src), .cons_wren(cons_wren),
    .cons_rd(cons_rd), .cons_load(cons_load),
    .fwd_sel(fwd_sel), .ld_stall(ld_stall)
  );

  always #5 clk = ~clk;

  function automatic int dut_sel(input int i);
    return int'(fwd_sel[i*SW +: SW]);
  endfunction

  function automatic int src_of(input int i);
    return int'(cons_src[i*AW +: AW]);
  endfunction

  // The youngest age that writes src supplies the operand.
  function automatic int exp_sel(input int src);
    for (int age = 1; age <= D; age++)
      if (m_v[age] && m_w[age] && m_rd[age] == src) return age;
    return 0;
  endfunction

  function automatic bit exp_stall();
`ifdef FWD_LOAD_INTERLOCK_EN
    bit dep = 1'b0;
    for (int i = 0; i < NS; i++) if (exp_sel(src_of(i)) == 1) dep = 1'b1;
    return cons_valid && dep && m_ld[1];
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive(input bit v, input int s0, input int s1, input bit w,
                       input int rd, input bit ld, input bit a, input bit f, input bit r);
    cons_valid = v;
    cons_src   = {AW'(s1), AW'(s0)};
    cons_wren  = w;
    cons_rd    = AW'(rd);
    cons_load  = ld;
    adv        = a;
    flush      = f;
    rst        = r;
    #1;
  endtask

  // Advance one clock. The model applies the rules to the inputs held across the edge.
  task automatic step();
    bit st;
    st = exp_stall();
    @(posedge clk);
    if (rst || flush) begin
      for (int age = 1; age <= D; age++) m_v[age] = 1'b0;
    end else if (adv) begin
      for (int age = D; age >= 2; age--) begin
        m_v[age] = m_v[age-1]; m_w[age] = m_w[age-1];
        m_rd[age] = m_rd[age-1]; m_ld[age] = m_ld[age-1];
      end
      m_v[1]  = cons_valid && !st;
      m_w[1]  = cons_wren;
      m_rd[1] = int'(cons_rd);
      m_ld[1] = cons_load;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 1, 0, 1, 1, 0, 1);
    step();
    for (int n = 0; n < 4; n++) begin
      drive(1, $urandom_range(7), $urandom_range(7), 1, $urandom_range(7), 1, 0, 0, 0);
      checks++;
      if (dut_sel(0) !== 0 || dut_sel(1) !== 0 || ld_stall !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: sel0=%0d sel1=%0d stall=%0b, want 0 0 0",
                 dut_sel(0), dut_sel(1), ld_stall);
      end
    end
  endtask

  task automatic test_alu_forward();
    drive(1, 0, 0, 1, 3, 0, 1, 0, 0);
    step();
    drive(1, 3, 6, 0, 0, 0, 0, 0, 0);
    checks++;
    if (dut_sel(0) !== 1) begin
      errors++; $display("FAIL alu_stage1: sel0=%0d want 1", dut_sel(0));
    end
    drive(1, 6, 6, 0, 0, 0, 1, 0, 0);
    step();
    drive(1, 3, 6, 0, 0, 0, 0, 0, 0);
    checks++;
    if (dut_sel(0) !== 2) begin
      errors++; $display("FAIL alu_stage2: sel0=%0d want 2", dut_sel(0));
    end
  endtask

  task automatic test_priority();
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
    step();
    drive(1, 0, 0, 1, 5, 0, 1, 0, 0); step();
    drive(1, 0, 0, 1, 5, 0, 1, 0, 0); step();
    drive(1, 0, 5, 0, 0, 0, 0, 0, 0);
    checks++;
    if (dut_sel(1) !== 1) begin
      errors++; $display("FAIL youngest_wins: sel1=%0d want 1", dut_sel(1));
    end
  endtask

  task automatic test_load_use();
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
    step();
    drive(1, 0, 0, 1, 2, 1, 1, 0, 0);
    step();
    drive(1, 2, 0, 1, 6, 0, 1, 0, 0);
`ifdef FWD_LOAD_INTERLOCK_EN
    checks++;
    if (ld_stall !== 1'b1) begin
      errors++; $display("FAIL load_use_stall: stall=%0b want 1", ld_stall);
    end
    step();
    checks++;
    if (ld_stall !== 1'b0 || dut_sel(0) !== 2) begin
      errors++; $display("FAIL load_use_release: stall=%0b sel0=%0d want 0 2", ld_stall, dut_sel(0));
    end
    drive(1, 2, 6, 0, 0, 0, 0, 0, 0);
    checks++;
    if (dut_sel(1) !== 0) begin
      errors++; $display("FAIL load_use_bubble: sel1=%0d want 0", dut_sel(1));
    end
`else
    checks++;
    if (ld_stall !== 1'b0 || dut_sel(0) !== 1) begin
      errors++; $display("FAIL load_forward: stall=%0b sel0=%0d want 0 1", ld_stall, dut_sel(0));
    end
    step();
    drive(1, 2, 6, 0, 0, 0, 0, 0, 0);
    checks++;
    if (dut_sel(0) !== 2 || dut_sel(1) !== 1) begin
      errors++; $display("FAIL load_no_bubble: sel0=%0d sel1=%0d want 2 1", dut_sel(0), dut_sel(1));
    end
`endif
  endtask

  task automatic test_no_wren_hold();
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
    step();
    drive(1, 0, 0, 1, 7, 0, 1, 0, 0); step();
    drive(1, 0, 0, 0, 4, 0, 1, 0, 0); step();
    for (int n = 0; n < 4; n++) begin
      drive(1, 4, 7, 1, 4, 0, 0, 0, 0);
      checks++;
      if (dut_sel(0) !== 0 || dut_sel(1) !== 2) begin
        errors++; $display("FAIL no_wren_hold[%0d]: sel0=%0d sel1=%0d want 0 2", n, dut_sel(0), dut_sel(1));
      end
      step();
    end
  endtask

  task automatic test_flush_reset();
    for (int pass = 0; pass < 2; pass++) begin
      drive(1, 0, 0, 1, 1, 0, 1, 0, 0); step();
      drive(1, 0, 0, 1, 1, 0, 1, 0, 0); step();
      drive(1, 1, 0, 1, 1, 0, 0, 0, 0);
      checks++;
      if (dut_sel(0) !== 1) begin
        errors++; $display("FAIL fill_r1[%0d]: sel0=%0d want 1", pass, dut_sel(0));
      end
      drive(1, 1, 1, 1, 1, 0, 1, pass == 0, pass == 1);
      step();
      drive(1, 1, 1, 1, 1, 0, 0, 0, 0);
      checks++;
      if (dut_sel(0) !== 0 || dut_sel(1) !== 0) begin
        errors++; $display("FAIL clear_r1[%0d]: sel0=%0d sel1=%0d want 0 0", pass, dut_sel(0), dut_sel(1));
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(3) != 0, $urandom_range(7), $urandom_range(7),
            $urandom_range(3) != 0, $urandom_range(7), $urandom_range(1) == 1,
            $urandom_range(3) != 0, $urandom_range(15) == 0, $urandom_range(31) == 0);
      checks++;
      if (dut_sel(0) !== exp_sel(src_of(0)) || dut_sel(1) !== exp_sel(src_of(1)) ||
          ld_stall !== exp_stall()) begin
        errors++;
        $display("FAIL random[%0d]: sel0=%0d sel1=%0d stall=%0b want %0d %0d %0b",
                 n, dut_sel(0), dut_sel(1), ld_stall,
                 exp_sel(src_of(0)), exp_sel(src_of(1)), exp_stall());
      end
      step();
    end
  endtask

  initial begin
    for (int age = 1; age <= D; age++) begin
      m_v[age] = 0; m_w[age] = 0; m_rd[age] = 0; m_ld[age] = 0;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    test_reset();
    test_alu_forward();
    test_priority();
    test_load_use();
    test_no_wren_hold();
    test_flush_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised forwarding and load-use interlock unit for the pipelined core. It tracks the destinations of in-flight instructions in an internal shift register of `FWD_DEPTH` stages. It then produces a priority-resolved bypass select for each of `NUM_SRC` source operands of the consuming instruction. It sits beside the decode/execute boundary, replaces external per-stage `RegRd`/`RegWren` wiring, and adds load-use stall generation.

## Interface
- `REG_ADDR_W`, 3, register address width
- `NUM_SRC`, 2, number of source operands per consumer
- `FWD_DEPTH`, 2, number of tracked producer stages (≥1); stage 1 is nearest the consumer
- `SEL_W`, derived = clog2(`FWD_DEPTH`+1), select width per source
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `adv`  in  1  pipeline advances this cycle
- `flush`  in  1  discard all in-flight entries
- `cons_valid`  in  1  consumer instruction present
- `cons_src`  in  `NUM_SRC`*`REG_ADDR_W`  packed source addresses; source i at bits [i*`REG_ADDR_W` +: `REG_ADDR_W`]
- `cons_wren`  in  1  consumer writes a register
- `cons_rd`  in  `REG_ADDR_W`  consumer destination
- `cons_load`  in  1  consumer is a load (result available one stage late)
- `fwd_sel`  out  `NUM_SRC`*`SEL_W`  per-source select; 0 = register file, k = stage k
- `ld_stall`  out  1  load-use stall request

## Operation
- State: `FWD_DEPTH` entries {valid, wren, rd, load}.
- Per source i: match stage k when entry k is valid, has wren set, and its rd equals src_i.
  - `fwd_sel`[i] = the smallest matching k (youngest producer wins), else 0.
  - Multiple matches never OR together.
- `ld_stall` = `cons_valid` and stage 1 valid, wren and load set and rd matching any source.
- Shift on a rising edge with `adv`=1 (entry k → k+1, entry `FWD_DEPTH` discarded). New stage 1 is:
  - the bubble {0,0,0,0} if `ld_stall`=1 or `cons_valid`=0;
  - otherwise {1, `cons_wren`, `cons_rd`, `cons_load`}.
- `adv`=0: state holds; outputs continue to track the inputs combinationally.
- Priority: `rst` > `flush` > `adv`.
  - `flush` clears all valid bits and does not push the consumer, regardless of `adv`.
- No special casing of register 0; every register is writable.
- `fwd_sel` for sources is computed even while `ld_stall`=1. The consumer must ignore it that cycle.

## Timing
- `fwd_sel` and `ld_stall` are combinational from state and `cons_*`; zero-cycle latency.
- A producer pushed at edge t is visible as stage 1 in cycle t+1 and as stage k after k advancing edges.
- Load-use: one bubble per dependent load. After one advance with stall, the load is at stage 2, `ld_stall` drops and `fwd_sel` = 2.
- Reset: all entries invalid. In the cycle after `rst`, `fwd_sel`=0 for all sources and `ld_stall`=0 for any inputs.
- `rst` mid-operation: state cleared at that edge; `adv`/`flush` that cycle ignored.
- `FWD_DEPTH`=1: `SEL_W`=1; a load at stage 1 always stalls a dependent consumer and is never forwarded.

## Configuration
- `FWD_LOAD_INTERLOCK_EN` defined:
  - load field stored;
  - `ld_stall` generated as above.
- Undefined:
  - load field not stored;
  - `ld_stall` tied 0;
  - `cons_load` ignored;
  - loads forward from stage 1 like ALU results.

## Structure
- Package `fwd_pkg`:
  - entry struct typedef (valid, wren, rd, load);
  - `FWD_SEL_RF`=0 constant;
  - clog2-based select-width function.
- Sub-module `fwd_match`: one source address against all entries, emitting the priority-encoded select and a stage-1-load hit. Instantiated `NUM_SRC` times via generate.
- Top holds the shift register, bubble insertion, flush/reset and the stall OR-reduction.

## Test plan
- Defaults: push ALU write r3 with `adv`=1, then consumer src0=r3 → `fwd_sel`[0]=1. One more advance with an unrelated consumer, then re-query src0=r3 → `fwd_sel`[0]=2.
- Consecutive writes to r5 at stages 1 and 2, consumer src1=r5 → `fwd_sel`[1]=1, never 3.
- Load to r2 at stage 1, consumer src0=r2 → `ld_stall`=1. Advance once → `ld_stall`=0, `fwd_sel`[0]=2, and stage 1 is a bubble.
- Producer with `cons_wren`=0, rd=r4, then consumer src0=r4 → `fwd_sel`[0]=0. `adv`=0 for 3 cycles → selects unchanged.
- Stages full of writes to r1, `flush`=1 with `adv`=1 → next cycle src0=r1 gives `fwd_sel`[0]=0. Repeat with `rst`=1 → same.
- `FWD_LOAD_INTERLOCK_EN` undefined: load r2 at stage 1, consumer src0=r2 → `ld_stall`=0, `fwd_sel`[0]=1.
